ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Parametrised, sequenced control-word generator: a handshaked opcode stream enters, each opcode indexes a runtime-programmable decode table, and the block emits that entry's control word for a programmable number of beats with back-pressure. It generalises the fixed 7-in/26-out combinational control decoder into a clocked block with configurable opcode and control widths and multi-beat operations. It sits between the instruction-issue stage and the datapath control inputs.

## Interface
- OP_W, 7: opcode width; table depth is 2**OP_W.
- CTRL_W, 26: control-word width.
- RPT_W, 3: repeat-count field width; beats per op = rpt+1 (1..2**RPT_W).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  opcode offered.
- in_ready  out  1  block accepts opcode this cycle.
- in_op  in  OP_W  opcode.
- out_valid  out  1  control beat valid.
- out_ready  in  1  datapath consumes beat.
- out_ctrl  out  CTRL_W  control word.
- out_last  out  1  final beat of current op.
- busy  out  1  op in flight (state EMIT).
- tbl_we  in  1  table write strobe.
- tbl_addr  in  OP_W  table write index.
- tbl_data  in  CTRL_W+RPT_W  {rpt, ctrl} entry.
- err  out  1  illegal-opcode pulse (see Configuration).
- err_cnt  out  8  illegal-opcode count, saturating at 255.

## Operation
- FSM states: IDLE, EMIT. Reset -> IDLE.
- Accept: in_valid && in_ready. in_ready = (IDLE) || (EMIT && out_ready && out_last).
- On accept: entry = table[in_op]; out_ctrl <= entry.ctrl; beat counter <= entry.rpt; state -> EMIT.
- EMIT: out_valid=1; out_last = (counter==0). On out_ready: counter==0 -> back-to-back accept if offered, else IDLE; counter!=0 -> decrement.
- out_ctrl, out_last stable while out_valid && !out_ready.
- Table: 2**OP_W entries, all zero on reset. Write on tbl_we at clock edge. Same-cycle write and accept to same index: lookup returns old contents; new value visible next cycle. Writes never affect a beat already captured.
- err_cnt saturates at 255; does not wrap.

## Timing
- Reset values: in_ready=1, out_valid=0, out_ctrl=0, out_last=0, busy=0, err=0, err_cnt=0, all table entries 0.
- Latency: accept at edge t -> out_valid high from cycle t+1.
- Throughput: one beat per cycle with out_ready held high; single-beat ops sustain one op per cycle.
- Reset mid-op: all in-flight beats discarded, outputs return to reset values asynchronously.

## Configuration
- CTRL_SEQ_ILLEGAL_EN defined: each entry carries a valid bit, set on write, cleared only by reset. Accepting an opcode whose entry is invalid produces no beats, pulses err for one cycle (t+1), increments err_cnt; FSM stays/returns to IDLE.
- Not defined: no valid bits; unwritten entries emit one all-zero beat with out_last=1; err and err_cnt tied to 0.

## Structure
- Package ctrl_seq_pkg: state enum (IDLE, EMIT), default widths, parametrised entry struct {valid (when enabled), rpt, ctrl}.
- Sub-module ctrl_seq_table: async-reset register file, one write port, one combinational read port, read-old-on-collision.
- Top holds FSM, beat counter, output registers, error logic.

## Test plan
- Reset: assert rst_n=0 mid-EMIT -> out_valid=0, out_ctrl=0, in_ready=1 immediately; table reads all-zero.
- Single beat: write entry 0x05={rpt=0, ctrl=0x2AAAAAA}; send op 0x05 -> one beat 0x2AAAAAA with out_last=1 at t+1.
- Multi-beat with back-pressure: entry 0x10 rpt=3; toggle out_ready 1,0,1,1,0,1 -> exactly 4 beats consumed, word stable while stalled, out_last on 4th only.
- Back-to-back: ops 0x05,0x05,0x05 with in_valid/out_ready held -> three consecutive beats, in_ready stays 1.
- Collision: tbl_we to 0x07 same cycle as accepting 0x07 -> old word emitted; next accept of 0x07 emits new word.
- Illegal (CTRL_SEQ_ILLEGAL_EN): send unwritten op 0x7F 300 times -> no out_valid, err pulses each, err_cnt ends at 255.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared types and default widths for the ctrl_seq control-word sequencer.
// CTRL_SEQ_ILLEGAL_EN adds a per-entry valid bit to the table entry.
package ctrl_seq_pkg;

  localparam int OP_W_DEF   = 7;
  localparam int CTRL_W_DEF = 26;
  localparam int RPT_W_DEF  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Entry layout at default widths; the top re-declares it with its own parameters.
  typedef struct packed {
`ifdef CTRL_SEQ_ILLEGAL_EN
    logic                  valid;
`endif
    logic [RPT_W_DEF-1:0]  rpt;
    logic [CTRL_W_DEF-1:0] ctrl;
  } entry_def_t;

  function automatic int entry_w(input int ctrl_w, input int rpt_w);
    return ctrl_w + rpt_w;
  endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// Opcode-in / control-beat-out handshake bundle for ctrl_seq.
interface ctrl_seq_if
  import ctrl_seq_pkg::*;
#(
  parameter int OP_W   = OP_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_last;

  modport master (
    output in_valid, in_op, out_ready,
    input  in_ready, out_valid, out_ctrl, out_last
  );

  modport slave (
    input  in_valid, in_op, out_ready,
    output in_ready, out_valid, out_ctrl, out_last
  );

endinterface

// File: rtl/ctrl_seq_table.sv
// Decode table: async-reset register file, one write port, one combinational read port.
// Reads see pre-edge contents, so a same-cycle write to the read index returns the old entry.
module ctrl_seq_table
  import ctrl_seq_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int ENT_W = CTRL_W_DEF + RPT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [OP_W-1:0]  wr_addr,
  input  logic [ENT_W-1:0] wr_data,
  input  logic [OP_W-1:0]  rd_addr,
`ifdef CTRL_SEQ_ILLEGAL_EN
  output logic             rd_valid,
`endif
  output logic [ENT_W-1:0] rd_data
);

  localparam int DEPTH = 2**OP_W;

  logic [ENT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

`ifdef CTRL_SEQ_ILLEGAL_EN
  // Valid bits only clear on reset; rewriting an entry keeps it legal.
  logic vld [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) vld[i] <= 1'b0;
    end else if (we) begin
      vld[wr_addr] <= 1'b1;
    end
  end

  assign rd_valid = vld[rd_addr];
`endif

endmodule

// File: rtl/ctrl_seq.sv
// Sequenced control-word generator: opcode -> table entry -> rpt+1 beats of ctrl.
// Optional feature macro: CTRL_SEQ_ILLEGAL_EN (unwritten opcodes raise err instead of a zero beat).
//
// state | meaning
// IDLE  | no op in flight, ready for an opcode
// EMIT  | presenting ctrl_q; cnt beats remain after the current one
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int OP_W   = OP_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int RPT_W  = RPT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ctrl_seq_if.slave               bus,
  input  logic                    tbl_we,
  input  logic [OP_W-1:0]         tbl_addr,
  input  logic [CTRL_W+RPT_W-1:0] tbl_data,
  output logic                    busy,
  output logic                    err,
  output logic [7:0]              err_cnt
);

  typedef struct packed {
    logic [RPT_W-1:0]  rpt;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  state_t            state, state_d;
  logic [RPT_W-1:0]  cnt, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  entry_t            rd_entry;
  logic              entry_ok;
  logic              last_c;
  logic              in_ready_c;
  logic              accept;

  ctrl_seq_table #(
    .OP_W  (OP_W),
    .ENT_W (CTRL_W + RPT_W)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (tbl_we),
    .wr_addr  (tbl_addr),
    .wr_data  (tbl_data),
    .rd_addr  (bus.in_op),
`ifdef CTRL_SEQ_ILLEGAL_EN
    .rd_valid (entry_ok),
`endif
    .rd_data  (rd_entry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ctrl_q <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      ctrl_q <= ctrl_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    ctrl_d     = ctrl_q;
    last_c     = (state == EMIT) && (cnt == '0);
    in_ready_c = (state == IDLE) || (last_c && bus.out_ready);
    accept     = bus.in_valid && in_ready_c;

    if ((state == EMIT) && bus.out_ready) begin
      if (cnt == '0) state_d = IDLE;
      else           cnt_d   = cnt - RPT_W'(1);
    end

    // A new accept overrides the drain to IDLE, giving back-to-back ops.
    if (accept) begin
      if (entry_ok) begin
        state_d = EMIT;
        cnt_d   = rd_entry.rpt;
        ctrl_d  = rd_entry.ctrl;
      end else begin
        state_d = IDLE;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state == EMIT);
  assign bus.out_last  = last_c;
  assign bus.out_ctrl  = ctrl_q;
  assign busy          = (state == EMIT);

`ifdef CTRL_SEQ_ILLEGAL_EN
  logic       err_q;
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= accept && !entry_ok;
      if (accept && !entry_ok && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`else
  assign entry_ok = 1'b1;
  assign err      = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: directed scenarios plus a randomized run against a queue model.
module tb_ctrl_seq;

  localparam int OP_W   = 7;
  localparam int CTRL_W = 26;
  localparam int RPT_W  = 3;
  localparam int ENT_W  = CTRL_W + RPT_W;
`ifdef CTRL_SEQ_ILLEGAL_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tbl_we;
  logic [OP_W-1:0]  tbl_addr;
  logic [ENT_W-1:0] tbl_data;
  logic             busy, err;
  logic [7:0]       err_cnt;

  always #5 clk = ~clk;

  ctrl_seq_if #(.OP_W(OP_W), .CTRL_W(CTRL_W)) bus ();

  ctrl_seq #(.OP_W(OP_W), .CTRL_W(CTRL_W), .RPT_W(RPT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .tbl_we   (tbl_we),
    .tbl_addr (tbl_addr),
    .tbl_data (tbl_data),
    .busy     (busy),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  // Model: table contents, and the beats still owed for the op in flight.
  logic [ENT_W-1:0]  m_tbl [128];
  bit                m_vld [128];
  logic [CTRL_W-1:0] q [$];
  bit                m_err;
  int                m_err_cnt;
  int                n_checks = 0;
  int                n_errors = 0;

  function automatic bit exp_ready();
    return (q.size() == 0) || (bus.out_ready && (q.size() == 1));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) begin
      m_tbl[i] = '0;
      m_vld[i] = 1'b0;
    end
    q.delete();
    m_err     = 1'b0;
    m_err_cnt = 0;
  endtask

  task automatic drive(input logic v, input logic [OP_W-1:0] op, input logic rdy,
                       input logic we, input logic [OP_W-1:0] wa, input logic [ENT_W-1:0] wd);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.out_ready = rdy;
    tbl_we        = we;
    tbl_addr      = wa;
    tbl_data      = wd;
    #1;
  endtask

  task automatic advance();
    bit               acc, fire, ok;
    logic [ENT_W-1:0] ent;
    acc  = bus.in_valid && exp_ready();
    fire = bus.out_ready && (q.size() != 0);
    ent  = m_tbl[bus.in_op];
    ok   = !ILL || m_vld[bus.in_op];
    @(posedge clk);
    if (fire) void'(q.pop_front());
    m_err = 1'b0;
    if (acc) begin
      if (ok) begin
        for (int k = 0; k <= int'(ent[ENT_W-1:CTRL_W]); k++) q.push_back(ent[CTRL_W-1:0]);
      end else begin
        m_err = 1'b1;
        if (m_err_cnt < 255) m_err_cnt++;
      end
    end
    if (tbl_we) begin
      m_tbl[tbl_addr] = tbl_data;
      m_vld[tbl_addr] = 1'b1;
    end
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.out_ctrl !== '0) begin n_errors++; $display("FAIL reset_out_ctrl got %h exp 0", bus.out_ctrl); end
    n_checks++; if (bus.out_last !== 1'b0) begin n_errors++; $display("FAIL reset_out_last got %b exp 0", bus.out_last); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b exp 0", err); end
    n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
  endtask

  task automatic test_single();
    drive(1'b0, '0, 1'b1, 1'b1, 7'h05, {3'd0, 26'h2AAAAAA});
    advance();
    drive(1'b1, 7'h05, 1'b1, 1'b0, '0, '0);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL single_in_ready got %b exp 1", bus.in_ready); end
    advance();
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid got %b exp 1", bus.out_valid); end
    n_checks++; if (bus.out_ctrl !== 26'h2AAAAAA) begin n_errors++; $display("FAIL single_ctrl got %h exp 2aaaaaa", bus.out_ctrl); end
    n_checks++; if (bus.out_last !== 1'b1) begin n_errors++; $display("FAIL single_last got %b exp 1", bus.out_last); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy got %b exp 1", busy); end
    advance();
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL single_done got %b exp 0", bus.out_valid); end
    advance();
  endtask

  task automatic test_backpressure();
    bit [5:0]          pat = 6'b101101;  // applied LSB first: 1,0,1,1,0,1
    logic [CTRL_W-1:0] w;
    int                seen = 0;
    w = CTRL_W'($urandom);
    drive(1'b0, '0, 1'b1, 1'b1, 7'h10, {3'd3, w});
    advance();
    drive(1'b1, 7'h10, 1'b1, 1'b0, '0, '0);
    advance();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, '0, pat[i], 1'b0, '0, '0);
      n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid[%0d] got %b exp 1", i, bus.out_valid); end
      n_checks++; if (bus.out_ctrl !== w) begin n_errors++; $display("FAIL bp_ctrl[%0d] got %h exp %h", i, bus.out_ctrl, w); end
      n_checks++; if (bus.out_last !== (seen == 3)) begin n_errors++; $display("FAIL bp_last[%0d] got %b exp %b", i, bus.out_last, seen == 3); end
      if (pat[i] && bus.out_valid) seen++;
      advance();
    end
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_done got %b exp 0", bus.out_valid); end
    n_checks++; if (seen != 4) begin n_errors++; $display("FAIL bp_beats got %0d exp 4", seen); end
    advance();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      drive(i < 3, 7'h05, 1'b1, 1'b0, '0, '0);
      n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", i, bus.in_ready); end
      n_checks++; if (bus.out_valid !== (i >= 1 && i <= 3)) begin n_errors++; $display("FAIL b2b_valid[%0d] got %b exp %b", i, bus.out_valid, i >= 1 && i <= 3); end
      if (i >= 1 && i <= 3) begin
        n_checks++; if (bus.out_ctrl !== 26'h2AAAAAA || bus.out_last !== 1'b1) begin
          n_errors++; $display("FAIL b2b_beat[%0d] got %h/%b exp 2aaaaaa/1", i, bus.out_ctrl, bus.out_last);
        end
      end
      advance();
    end
  endtask

  task automatic test_collision();
    logic [CTRL_W-1:0] w_old, w_new;
    w_old = CTRL_W'($urandom);
    w_new = ~w_old;
    drive(1'b0, '0, 1'b1, 1'b1, 7'h07, {3'd0, w_old});
    advance();
    drive(1'b1, 7'h07, 1'b1, 1'b1, 7'h07, {3'd0, w_new});
    advance();
    drive(1'b1, 7'h07, 1'b1, 1'b0, '0, '0);
    n_checks++; if (bus.out_ctrl !== w_old || bus.out_valid !== 1'b1) begin
      n_errors++; $display("FAIL coll_old got %h/%b exp %h/1", bus.out_ctrl, bus.out_valid, w_old);
    end
    advance();
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    n_checks++; if (bus.out_ctrl !== w_new || bus.out_valid !== 1'b1) begin
      n_errors++; $display("FAIL coll_new got %h/%b exp %h/1", bus.out_ctrl, bus.out_valid, w_new);
    end
    advance();
  endtask

`ifdef CTRL_SEQ_ILLEGAL_EN
  task automatic test_illegal();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 7'h7F, 1'b1, 1'b0, '0, '0);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL ill_valid[%0d] got %b exp 0", i, bus.out_valid); end
      n_checks++; if (err !== m_err) begin n_errors++; $display("FAIL ill_err[%0d] got %b exp %b", i, err, m_err); end
      advance();
    end
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL ill_last_err got %b exp 1", err); end
    n_checks++; if (err_cnt !== 8'd255) begin n_errors++; $display("FAIL ill_err_cnt got %0d exp 255", err_cnt); end
    advance();
  endtask
`else
  task automatic test_unwritten();
    drive(1'b1, 7'h7F, 1'b1, 1'b0, '0, '0);
    advance();
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL unw_valid got %b exp 1", bus.out_valid); end
    n_checks++; if (bus.out_ctrl !== '0) begin n_errors++; $display("FAIL unw_ctrl got %h exp 0", bus.out_ctrl); end
    n_checks++; if (bus.out_last !== 1'b1) begin n_errors++; $display("FAIL unw_last got %b exp 1", bus.out_last); end
    n_checks++; if (err !== 1'b0 || err_cnt !== 8'd0) begin n_errors++; $display("FAIL unw_err got %b/%0d exp 0/0", err, err_cnt); end
    advance();
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL unw_done got %b exp 0", bus.out_valid); end
    advance();
  endtask
`endif

  task automatic test_random();
    logic v, rdy, we;
    logic [OP_W-1:0] op, wa;
    logic [ENT_W-1:0] wd;
    for (int n = 0; n < 1500; n++) begin
      v   = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 9) < 7);
      we  = ($urandom_range(0, 3) == 0);
      op  = OP_W'($urandom_range(0, 11));
      wa  = OP_W'($urandom_range(0, 7));
      wd  = ENT_W'({$urandom, $urandom});
      drive(v, op, rdy, we, wa, wd);
      n_checks++; if (bus.in_ready !== exp_ready()) begin n_errors++; $display("FAIL rnd_in_ready[%0d] got %b exp %b", n, bus.in_ready, exp_ready()); end
      n_checks++; if (bus.out_valid !== (q.size() != 0)) begin n_errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", n, bus.out_valid, q.size() != 0); end
      n_checks++; if (bus.out_last !== (q.size() == 1)) begin n_errors++; $display("FAIL rnd_last[%0d] got %b exp %b", n, bus.out_last, q.size() == 1); end
      n_checks++; if (busy !== (q.size() != 0)) begin n_errors++; $display("FAIL rnd_busy[%0d] got %b exp %b", n, busy, q.size() != 0); end
      n_checks++; if (err !== m_err || err_cnt !== 8'(m_err_cnt)) begin
        n_errors++; $display("FAIL rnd_err[%0d] got %b/%0d exp %b/%0d", n, err, err_cnt, m_err, m_err_cnt);
      end
      if (q.size() != 0) begin
        n_checks++; if (bus.out_ctrl !== q[0]) begin n_errors++; $display("FAIL rnd_ctrl[%0d] got %h exp %h", n, bus.out_ctrl, q[0]); end
      end
      advance();
    end
    // Drain whatever op is still in flight.
    for (int n = 0; n < 10; n++) begin
      drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
      advance();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, '0, 1'b1, 1'b1, 7'h22, {3'd7, CTRL_W'($urandom) | 26'h1});
    advance();
    drive(1'b1, 7'h22, 1'b0, 1'b0, '0, '0);
    advance();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    advance();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL rmid_pre_valid got %b exp 1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.out_ctrl !== '0) begin n_errors++; $display("FAIL rmid_ctrl got %h exp 0", bus.out_ctrl); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL rmid_in_ready got %b exp 1", bus.in_ready); end
    n_checks++; if (busy !== 1'b0 || bus.out_last !== 1'b0) begin n_errors++; $display("FAIL rmid_busy_last got %b/%b exp 0/0", busy, bus.out_last); end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 7'h22, 1'b1, 1'b0, '0, '0);
    advance();
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    n_checks++; if (bus.out_valid !== (q.size() != 0)) begin n_errors++; $display("FAIL rmid_tbl_valid got %b exp %b", bus.out_valid, q.size() != 0); end
    n_checks++; if (bus.out_ctrl !== '0) begin n_errors++; $display("FAIL rmid_tbl_ctrl got %h exp 0", bus.out_ctrl); end
    n_checks++; if (err !== m_err) begin n_errors++; $display("FAIL rmid_tbl_err got %b exp %b", err, m_err); end
    advance();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    tbl_we        = 1'b0;
    tbl_addr      = '0;
    tbl_data      = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_collision();
`ifdef CTRL_SEQ_ILLEGAL_EN
    test_illegal();
`else
    test_unwritten();
`endif
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
